// File: rtl/ddr3_frame_fetch_if.sv
// Avalon-MM read port and pixel-FIFO write port of the frame fetch engine.
interface ddr3_frame_fetch_if #(
    parameter int unsigned ADDR_W = 26,
    parameter int unsigned CNT_W  = 9
);
    logic              avl_ready;
    logic              avl_burstbegin;
    logic [2:0]        avl_size;
    logic              avl_read_req;
    logic [ADDR_W-1:0] avl_addr;
    logic              avl_rdata_valid;
    logic [127:0]      avl_rdata;
    logic [CNT_W-1:0]  fifo_free;
    logic              fifo_wr_en;
    logic [127:0]      fifo_wr_data;

    modport master (
        input  avl_ready, avl_rdata_valid, avl_rdata, fifo_free,
        output avl_burstbegin, avl_size, avl_read_req, avl_addr, fifo_wr_en, fifo_wr_data
    );

    modport slave (
        output avl_ready, avl_rdata_valid, avl_rdata, fifo_free,
        input  avl_burstbegin, avl_size, avl_read_req, avl_addr, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/ddr3_frame_fetch.sv
// Frame-buffer read engine: walks one frame with Avalon burst reads and
// fills the VGA pixel FIFO without ever exceeding its free space.
module ddr3_frame_fetch #(
    parameter int unsigned ADDR_W    = 26,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  frame_start,
    input  logic [ADDR_W-1:0]     frame_base,
    input  logic [19:0]           frame_words,
    ddr3_frame_fetch_if.master    bus,
    output logic                  frame_done,
    output logic                  busy
);
    localparam int unsigned WORDS_W = 20;
    localparam int unsigned SUM_W   = CNT_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_REQ   = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WORDS_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic               pend_q, pend_d;
    logic [ADDR_W-1:0]  pend_base_q, pend_base_d;
    logic [WORDS_W-1:0] pend_words_q, pend_words_d;
    logic               req_q, req_d;
    logic               bb_q, bb_d;
    logic [2:0]         size_q, size_d;
    logic [ADDR_W-1:0]  aaddr_q, aaddr_d;
    logic               wr_en_q;
    logic [127:0]       wr_data_q;
    logic               done_q, done_d;
    logic               busy_q;

    logic [2:0]         sz;
    logic [SUM_W-1:0]   credit;
    logic               credit_ok;
    logic               accept;
    logic               beat_dec;

    assign sz = (remain_q >= WORDS_W'(BURST_LEN)) ? 3'(BURST_LEN) : remain_q[2:0];

    // A write issued last cycle is not yet reflected in the FIFO's registered free count.
    assign credit    = SUM_W'(bus.fifo_free) - SUM_W'(outst_q) - SUM_W'(wr_en_q);
    assign credit_ok = !credit[CNT_W] && (credit[CNT_W-1:0] >= CNT_W'(sz));

    assign accept   = req_q & bus.avl_ready;
    assign beat_dec = bus.avl_rdata_valid && ((outst_q != '0) || accept);
    assign outst_d  = outst_q + (accept ? CNT_W'(size_q) : '0) - (beat_dec ? CNT_W'(1) : '0);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remain_d     = remain_q;
        pend_d       = pend_q;
        pend_base_d  = pend_base_q;
        pend_words_d = pend_words_q;
        req_d        = req_q;
        bb_d         = 1'b0;
        size_d       = size_q;
        aaddr_d      = aaddr_q;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_start && enable) begin
                    addr_d   = frame_base;
                    remain_d = frame_words;
                    if (frame_words == '0) done_d  = 1'b1;
                    else                   state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (frame_start) begin
                    addr_d   = frame_base;
                    remain_d = frame_words;
                    state_d  = (outst_d == '0) ? S_CHECK : S_DRAIN;
                end else if (!enable) begin
                    state_d = (outst_d == '0) ? S_IDLE : S_DRAIN;
                end else if (remain_q == '0) begin
                    state_d = S_WAIT;
                end else if (credit_ok) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    bb_d    = 1'b1;
                    size_d  = sz;
                    aaddr_d = addr_q;
                end
            end
            S_REQ: begin
                // A restart seen here is held until the presented burst is accepted.
                if (frame_start) begin
                    pend_d       = 1'b1;
                    pend_base_d  = frame_base;
                    pend_words_d = frame_words;
                end
                if (accept) begin
                    req_d = 1'b0;
                    if (frame_start || pend_q) begin
                        addr_d   = frame_start ? frame_base : pend_base_q;
                        remain_d = frame_start ? frame_words : pend_words_q;
                        pend_d   = 1'b0;
                        state_d  = (outst_d == '0) ? S_CHECK : S_DRAIN;
                    end else begin
                        addr_d   = addr_q + ADDR_W'(size_q);
                        remain_d = remain_q - WORDS_W'(size_q);
                        state_d  = S_CHECK;
                    end
                end
            end
            S_WAIT: begin
                if (outst_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                    if (frame_start) begin
                        addr_d   = frame_base;
                        remain_d = frame_words;
                        state_d  = S_CHECK;
                    end
                end else if (frame_start) begin
                    addr_d   = frame_base;
                    remain_d = frame_words;
                    state_d  = (outst_d == '0) ? S_CHECK : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (frame_start) begin
                    addr_d   = frame_base;
                    remain_d = frame_words;
                end
                if (outst_q == '0) state_d = enable ? S_CHECK : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            remain_q     <= '0;
            outst_q      <= '0;
            pend_q       <= 1'b0;
            pend_base_q  <= '0;
            pend_words_q <= '0;
            req_q        <= 1'b0;
            bb_q         <= 1'b0;
            size_q       <= '0;
            aaddr_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remain_q     <= remain_d;
            outst_q      <= outst_d;
            pend_q       <= pend_d;
            pend_base_q  <= pend_base_d;
            pend_words_q <= pend_words_d;
            req_q        <= req_d;
            bb_q         <= bb_d;
            size_q       <= size_d;
            aaddr_q      <= aaddr_d;
            wr_en_q      <= bus.avl_rdata_valid && (state_q != S_DRAIN);
            if (bus.avl_rdata_valid) wr_data_q <= bus.avl_rdata;
            done_q       <= done_d;
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign bus.avl_read_req   = req_q;
    assign bus.avl_burstbegin = bb_q;
    assign bus.avl_size       = size_q;
    assign bus.avl_addr       = aaddr_q;
    assign bus.fifo_wr_en     = wr_en_q;
    assign bus.fifo_wr_data   = wr_data_q;
    assign frame_done         = done_q;
    assign busy               = busy_q;
endmodule

// File: tb/tb_ddr3_frame_fetch.sv
// Scoreboard bench for ddr3_frame_fetch: directed frames, expected bursts and
// FIFO writes queued by the stimulus and checked by a negedge monitor.
module tb_ddr3_frame_fetch;
    localparam int unsigned ADDR_W    = 26;
    localparam int unsigned CNT_W     = 9;
    localparam int unsigned BURST_LEN = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        size;
    } req_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic              frame_start = 1'b0;
    logic [ADDR_W-1:0] frame_base = '0;
    logic [19:0]       frame_words = '0;
    logic              frame_done;
    logic              busy;

    ddr3_frame_fetch_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    ddr3_frame_fetch #(.ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .frame_start (frame_start),
        .frame_base  (frame_base),
        .frame_words (frame_words),
        .bus         (bus),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    req_t              exp_req[$];
    logic [ADDR_W-1:0] beat_q[$];
    logic [127:0]      exp_data[$];
    req_t              mon_e;

    int checks = 0, failures = 0;
    int acc_cnt = 0, wr_cnt = 0, done_cnt = 0, req_cycles = 0, cyc = 0;
    int last_wr_cyc = 0, done_cyc = 0, ovf_viol = 0;
    bit ovf_watch = 1'b0;

    function automatic logic [127:0] mk_data(input logic [ADDR_W-1:0] a);
        return {32'hA5A5_0000 ^ 32'(a), 32'(a) + 32'd1, ~32'(a), 32'(a)};
    endfunction

    task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Monitor: checks every accepted burst and every FIFO write against the queues.
    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            if (bus.avl_read_req) req_cycles++;
            if (bus.avl_read_req && bus.avl_ready) begin
                acc_cnt++;
                if (exp_req.size() == 0) begin
                    fail_now($sformatf("unexpected_req addr=%0h size=%0d", bus.avl_addr, bus.avl_size));
                end else begin
                    mon_e = exp_req.pop_front();
                    check_eq("req_addr", 128'(bus.avl_addr), 128'(mon_e.addr));
                    check_eq("req_size", 128'(bus.avl_size), 128'(mon_e.size));
                end
                for (int i = 0; i < int'(bus.avl_size); i++) beat_q.push_back(bus.avl_addr + ADDR_W'(i));
            end
            if (bus.fifo_wr_en) begin
                wr_cnt++;
                last_wr_cyc = cyc;
                if (exp_data.size() == 0) fail_now($sformatf("unexpected_fifo_write data=%0h", bus.fifo_wr_data));
                else check_eq("fifo_wr_data", bus.fifo_wr_data, exp_data.pop_front());
            end
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (ovf_watch && (dut.outst_q > bus.fifo_free)) ovf_viol++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [ADDR_W-1:0] base, input logic [19:0] words);
        frame_base  = base;
        frame_words = words;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic push_req(input logic [ADDR_W-1:0] a, input logic [2:0] s);
        req_t r;
        r.addr = a;
        r.size = s;
        exp_req.push_back(r);
    endtask

    task automatic wait_acc(input int target, input string name);
        int n = 0;
        while (acc_cnt < target && n < 200) begin
            tick();
            n++;
        end
        if (acc_cnt < target) fail_now($sformatf("%s timeout waiting for accept", name));
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 200) begin
            tick();
            n++;
        end
        if (done_cnt < target) fail_now($sformatf("%s timeout waiting for frame_done", name));
    endtask

    task automatic send_beat(input bit drop);
        logic [ADDR_W-1:0] a;
        if (beat_q.size() == 0) begin
            fail_now("no_beat_owed");
            a = '0;
        end else begin
            a = beat_q.pop_front();
        end
        bus.avl_rdata_valid = 1'b1;
        bus.avl_rdata       = mk_data(a);
        if (!drop) exp_data.push_back(mk_data(a));
    endtask

    task automatic beats(input int n, input bit drop);
        for (int i = 0; i < n; i++) begin
            send_beat(drop);
            tick();
        end
        bus.avl_rdata_valid = 1'b0;
    endtask

    initial begin
        int snap;
        int n;
        bus.avl_ready       = 1'b1;
        bus.avl_rdata_valid = 1'b0;
        bus.avl_rdata       = '0;
        bus.fifo_free       = CNT_W'(256);

        repeat (3) tick();
        check_eq("reset_outputs",
                 128'({bus.avl_read_req, bus.avl_burstbegin, bus.avl_size, bus.avl_addr,
                       bus.fifo_wr_en, frame_done, busy}), 128'(0));
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();

        // 1: plain 10-word frame
        push_req(26'h100, 3'd4);
        push_req(26'h104, 3'd4);
        push_req(26'h108, 3'd2);
        snap = wr_cnt;
        start_frame(26'h100, 20'd10);
        check_eq("busy_after_start", 128'(busy), 128'(1));
        wait_acc(3, "t1");
        beats(10, 1'b0);
        wait_done(1, "t1");
        check_eq("t1_writes", 128'(wr_cnt - snap), 128'(10));
        check_eq("t1_done_latency", 128'(done_cyc), 128'(last_wr_cyc + 1));
        tick();
        check_eq("t1_idle", 128'(busy), 128'(0));

        // 2: waitrequest held for 5 cycles on the first burst
        bus.avl_ready = 1'b0;
        push_req(26'h200, 3'd4);
        snap = acc_cnt;
        start_frame(26'h200, 20'd4);
        n = 0;
        while (!bus.avl_read_req && n < 20) begin
            tick();
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("t2_hold_cycle%0d", k),
                     128'({bus.avl_read_req, bus.avl_addr, bus.avl_size, bus.avl_burstbegin}),
                     128'({1'b1, 26'h200, 3'd4, (k == 0)}));
            tick();
        end
        bus.avl_ready = 1'b1;
        tick();
        check_eq("t2_one_accept", 128'(acc_cnt - snap), 128'(1));
        check_eq("t2_req_dropped", 128'(bus.avl_read_req), 128'(0));
        beats(4, 1'b0);
        wait_done(2, "t2");

        // 3: insufficient FIFO credit blocks the request
        bus.fifo_free = CNT_W'(3);
        ovf_watch = 1'b1;
        snap = req_cycles;
        start_frame(26'h300, 20'd4);
        repeat (20) tick();
        check_eq("t3_no_req_at_free3", 128'(req_cycles - snap), 128'(0));
        check_eq("t3_busy_waiting", 128'(busy), 128'(1));
        push_req(26'h300, 3'd4);
        bus.fifo_free = CNT_W'(4);
        wait_acc(acc_cnt + 1, "t3");
        beats(4, 1'b0);
        wait_done(3, "t3");
        ovf_watch = 1'b0;
        check_eq("t3_outstanding_le_free", 128'(ovf_viol), 128'(0));

        // 4: restart with 5 beats outstanding drops them and refetches from the new base
        bus.fifo_free = CNT_W'(8);
        push_req(26'h400, 3'd4);
        push_req(26'h404, 3'd4);
        snap = acc_cnt;
        start_frame(26'h400, 20'd12);
        wait_acc(snap + 2, "t4");
        beats(3, 1'b0);
        repeat (3) tick();
        check_eq("t4_outstanding5", 128'(dut.outst_q), 128'(5));
        check_eq("t4_no_third_burst", 128'(acc_cnt - snap), 128'(2));
        push_req(26'h500, 3'd4);
        snap = done_cnt;
        start_frame(26'h500, 20'd4);
        beats(5, 1'b1);
        wait_acc(acc_cnt + 1, "t4_restart");
        beats(4, 1'b0);
        wait_done(snap + 1, "t4");
        repeat (5) tick();
        check_eq("t4_single_done", 128'(done_cnt - snap), 128'(1));
        check_eq("t4_no_pending_writes", 128'(exp_data.size()), 128'(0));
        bus.fifo_free = CNT_W'(256);

        // 5: accept and returning beat in the same cycle
        push_req(26'h600, 3'd4);
        push_req(26'h604, 3'd4);
        snap = done_cnt;
        start_frame(26'h600, 20'd8);
        wait_acc(acc_cnt + 1, "t5");
        bus.avl_ready = 1'b0;
        send_beat(1'b0);
        tick();
        check_eq("t5_outstanding3", 128'({bus.avl_read_req, dut.outst_q}), 128'({1'b1, 9'd3}));
        send_beat(1'b0);
        bus.avl_ready = 1'b1;
        tick();
        check_eq("t5_outstanding6", 128'(dut.outst_q), 128'(6));
        beats(6, 1'b0);
        wait_done(snap + 1, "t5");

        // 6: asynchronous reset in the middle of a request
        push_req(26'h700, 3'd4);
        start_frame(26'h700, 20'd8);
        wait_acc(acc_cnt + 1, "t6");
        bus.avl_ready = 1'b0;
        n = 0;
        while (!bus.avl_read_req && n < 20) begin
            tick();
            n++;
        end
        check_eq("t6_outstanding4", 128'({bus.avl_read_req, dut.outst_q}), 128'({1'b1, 9'd4}));
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t6_async_reset_outputs",
                 128'({bus.avl_read_req, bus.avl_burstbegin, bus.avl_size, bus.avl_addr,
                       bus.fifo_wr_en, frame_done, busy}), 128'(0));
        exp_req.delete();
        beat_q.delete();
        tick();
        reset_n = 1'b1;
        tick();
        snap = req_cycles;
        for (int i = 0; i < 2; i++) begin
            bus.avl_rdata_valid = 1'b1;
            bus.avl_rdata       = mk_data(26'h3FF0 + 26'(i));
            exp_data.push_back(mk_data(26'h3FF0 + 26'(i)));
            tick();
        end
        bus.avl_rdata_valid = 1'b0;
        repeat (10) tick();
        check_eq("t6_idle_after_reset", 128'({busy, dut.outst_q}), 128'(0));
        check_eq("t6_no_req_after_reset", 128'(req_cycles - snap), 128'(0));
        bus.avl_ready = 1'b1;
        push_req(26'h800, 3'd4);
        snap = done_cnt;
        start_frame(26'h800, 20'd4);
        wait_acc(acc_cnt + 1, "t6_after");
        beats(4, 1'b0);
        wait_done(snap + 1, "t6");

        repeat (4) tick();
        check_eq("final_req_queue_empty", 128'(exp_req.size()), 128'(0));
        check_eq("final_data_queue_empty", 128'(exp_data.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
